// File: rtl/spi_transaction_fsm.sv
// SPI memory transaction controller: counts SCLK edges, latches address/RW, sequences mem write, SR load, MISO enable.
// Latency: LATCH 1 clk after 8th address pulse; sr_we 1+MEM_RD_LAT clks after LATCH; dm_we 1 clk after 8th data pulse.
// Backpressure: none; cs high aborts any frame next clk. Optional debug LEDs via `define SPI_FSM_LEDS_EN.
module spi_transaction_fsm #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs,
    input  logic                  sclk_pos,
    input  logic [DATA_WIDTH-1:0] shiftreg_p,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  dm_we,
    output logic                  sr_we,
    output logic                  miso_buff
`ifdef SPI_FSM_LEDS_EN
    ,
    output logic [3:0]            leds
`endif
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    // READ_WAIT reuses bit_cnt as its cycle counter; unreachable when MEM_RD_LAT is 0
    localparam logic [CNT_W-1:0] LAT_LAST = (MEM_RD_LAT > 0) ? CNT_W'(MEM_RD_LAT - 1) : '0;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        GET_ADDR   = 4'd1,
        LATCH      = 4'd2,
        READ_WAIT  = 4'd3,
        READ_LOAD  = 4'd4,
        READ_SEND  = 4'd5,
        WRITE_RECV = 4'd6,
        WRITE_MEM  = 4'd7,
        DONE       = 4'd8
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rw;
    logic             latch_en;

    // Next-state and counter decode; a high cs overrides everything, including a same-cycle sclk_pos
    always_comb begin
        nxt      = state;
        cnt_nxt  = bit_cnt;
        latch_en = 1'b0;
        if (cs) begin
            nxt     = IDLE;
            cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    nxt     = GET_ADDR;
                    cnt_nxt = '0;
                end
                GET_ADDR: begin
                    if (sclk_pos) begin
                        if (bit_cnt == LAST_BIT) begin
                            nxt     = LATCH;
                            cnt_nxt = '0;
                        end else begin
                            cnt_nxt = bit_cnt + CNT_ONE;
                        end
                    end
                end
                LATCH: begin
                    // shiftreg_p holds the full {addr, rw} byte by now
                    latch_en = 1'b1;
                    cnt_nxt  = '0;
                    if (shiftreg_p[0]) begin
                        nxt = (MEM_RD_LAT == 0) ? READ_LOAD : READ_WAIT;
                    end else begin
                        nxt = WRITE_RECV;
                    end
                end
                READ_WAIT: begin
                    if (bit_cnt == LAT_LAST) begin
                        nxt     = READ_LOAD;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = bit_cnt + CNT_ONE;
                    end
                end
                READ_LOAD: begin
                    nxt     = READ_SEND;
                    cnt_nxt = '0;
                end
                READ_SEND, WRITE_RECV: begin
                    // Both data phases count one byte of SCLK; the latched rw picks the exit
                    if (sclk_pos) begin
                        if (bit_cnt == LAST_BIT) begin
                            nxt     = rw ? DONE : WRITE_MEM;
                            cnt_nxt = '0;
                        end else begin
                            cnt_nxt = bit_cnt + CNT_ONE;
                        end
                    end
                end
                WRITE_MEM: begin
                    nxt = DONE;
                end
                DONE: begin
                    nxt = DONE;
                end
                default: begin
                    nxt     = IDLE;
                    cnt_nxt = '0;
                end
            endcase
        end
    end

    // State, counter, address latch and outputs; outputs are registered decodes of the next state
    // so they always coincide with the state they belong to
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            mem_addr  <= '0;
            rw        <= 1'b0;
            dm_we     <= 1'b0;
            sr_we     <= 1'b0;
            miso_buff <= 1'b0;
`ifdef SPI_FSM_LEDS_EN
            leds      <= 4'd0;
`endif
        end else begin
            state   <= nxt;
            bit_cnt <= cnt_nxt;
            if (latch_en) begin
                mem_addr <= shiftreg_p[DATA_WIDTH-1:1];
                rw       <= shiftreg_p[0];
            end
            dm_we     <= (nxt == WRITE_MEM);
            sr_we     <= (nxt == READ_LOAD);
            miso_buff <= (nxt == READ_SEND);
`ifdef SPI_FSM_LEDS_EN
            leds      <= nxt;
`endif
        end
    end

endmodule
